// File: rtl/div_seq_if.sv
// Handshake and data bundle between the EX stage and the sequential divider.
// EX drives operands, start and annul; the divider returns the result pair,
// the result-valid flag and the busy flag EX folds into its stall request.
interface div_seq_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring radix-2 divider for the EX stage.
// One quotient bit is produced per cycle on operand magnitudes; the sign
// fix-up is applied once the last bit is in. result_o carries
// {remainder, quotient} for the HI/LO write path.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    BYZERO,
    ON,
    END
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic                  neg1_q, neg1_d;
  logic                  neg2_q, neg2_d;
  logic                  sdiv_q, sdiv_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W:0]       trial;
  logic [DATA_W-1:0]     op1_abs;
  logic [DATA_W-1:0]     op2_abs;
  logic                  op1_neg;
  logic                  op2_neg;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;

  // The shifted partial remainder can reach 2*divisor-1, so the trial
  // subtraction is one bit wider than the operands; its MSB is the borrow.
  assign trial   = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dvs_q};

  // Operand magnitudes, negated only for a signed divide with the MSB set.
  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  assign quo_fix = (sdiv_q && (neg1_q ^ neg2_q)) ? -dvd_q : dvd_q;
  assign rem_fix = (sdiv_q && neg1_q) ? -rem_q : rem_q;

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = (state_q == ON) || (state_q == BYZERO);

  // Next-state and datapath update; every register holds unless a state says otherwise.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    sdiv_d   = sdiv_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      IDLE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          cnt_d  = '0;
          rem_d  = '0;
          dvd_d  = op1_abs;
          dvs_d  = op2_abs;
          neg1_d = op1_neg;
          neg2_d = op2_neg;
          sdiv_d = bus.signed_div_i;
          if (bus.opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
          end
        end
      end

      BYZERO: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d   = '0;
          dvd_d   = '0;
          state_d = END;
        end
      end

      ON: begin
        if (bus.annul_i) begin
          state_d  = IDLE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == CNT_W'(DATA_W)) begin
          dvd_d   = quo_fix;
          rem_d   = rem_fix;
          cnt_d   = '0;
          state_d = END;
        end else begin
          if (!trial[DATA_W]) begin
            rem_d = trial[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
            dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      END: begin
        if (bus.start_i) begin
          result_d = {rem_q, dvd_q};
          ready_d  = 1'b1;
        end else begin
          state_d  = IDLE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything and drops any divide in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      sdiv_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      sdiv_q   <= sdiv_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed divides, divide-by-zero,
// annul, signed overflow and reset in the middle of an operation.
module tb_div_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div_seq_if #(.DATA_W(32)) bus ();

  div_seq #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
  endtask

  // Full handshake: start, wait (bounded) for ready, check latency, busy
  // duration and result, hold one more cycle, then release start.
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expRes,
                        input int expLat, input int expBusy);
    int lat;
    int busyCnt;
    applyStimulus(sgn, a, b);
    tick();
    bus.opdata1_i    = ~a;
    bus.opdata2_i    = 32'd0;
    bus.signed_div_i = ~sgn;
    lat     = 0;
    busyCnt = bus.busy_o ? 1 : 0;
    while (!bus.ready_o && lat < 60) begin
      tick();
      lat++;
      if (bus.busy_o) busyCnt++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_busy_cycles"}, 64'(busyCnt), 64'(expBusy));
    checkOutput({tag, "_result"}, bus.result_o, expRes);
    checkOutput({tag, "_busy_at_ready"}, 64'(bus.busy_o), 64'd0);
    tick();
    checkOutput({tag, "_ready_held"}, 64'(bus.ready_o), 64'd1);
    checkOutput({tag, "_result_held"}, bus.result_o, expRes);
    bus.start_i = 1'b0;
    tick();
    checkOutput({tag, "_ready_clear"}, 64'(bus.ready_o), 64'd0);
    checkOutput({tag, "_result_clear"}, bus.result_o, 64'd0);
  endtask

  initial begin
    int readyCnt;
    clk      = 1'b0;
    rst      = 1'b1;
    checks   = 0;
    failures = 0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_result", bus.result_o, 64'd0);
    checkOutput("reset_ready", 64'(bus.ready_o), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy_o), 64'd0);

    $display("[TB] unsigned 100/7");
    runDiv("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 33);

    $display("[TB] signed -7/2 and 7/-2");
    runDiv("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 33);
    runDiv("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 34, 33);

    $display("[TB] divide by zero");
    runDiv("byzero", 1'b0, 32'd5, 32'd0, 64'd0, 2, 1);

    $display("[TB] annul during ON");
    applyStimulus(1'b0, 32'd1000, 32'd3);
    tick();
    repeat (9) tick();
    checkOutput("annul_busy_before", 64'(bus.busy_o), 64'd1);
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    checkOutput("annul_busy_after", 64'(bus.busy_o), 64'd0);
    checkOutput("annul_ready_after", 64'(bus.ready_o), 64'd0);
    readyCnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ready_o) readyCnt++;
    end
    checkOutput("annul_no_ready", 64'(readyCnt), 64'd0);
    runDiv("u_ffff_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 34, 33);

    $display("[TB] overflow corner");
    runDiv("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34, 33);
    runDiv("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 34, 33);

    $display("[TB] reset during ON");
    applyStimulus(1'b0, 32'd50, 32'd5);
    tick();
    repeat (19) tick();
    checkOutput("rst_busy_before", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("rst_busy_after", 64'(bus.busy_o), 64'd0);
    checkOutput("rst_ready_after", 64'(bus.ready_o), 64'd0);
    checkOutput("rst_result_after", bus.result_o, 64'd0);
    rst = 1'b0;
    runDiv("after_rst", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequential 32-bit divider controller for the EX stage.
- Performs signed and unsigned division using restoring radix-2 iteration, one quotient bit per cycle.
- Produces the {remainder, quotient} pair for the HI/LO write path.
- Exposes busy_o so EX can raise a pipeline stall request while a division is in flight. Sits beside EX; EX drives the operands, start and annul, and consumes the result.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- signed_div_i  in  1  1 = signed division (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- start_i  in  1  request division; level, held by EX until ready_o is seen
- annul_i  in  1  abort the current division (pipeline flush)
- result_o  out  2*DATA_W  [63:32] remainder (to HI), [31:0] quotient (to LO)
- ready_o  out  1  result_o valid
- busy_o  out  1  division in progress; EX ORs this into its stall request

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, cnt=0, result_o=0, ready_o=0, busy_o=0. Reset has priority over every other input and aborts any operation in flight.
- States: IDLE, BYZERO, ON, END.
- busy_o = (state==ON) || (state==BYZERO). It is decoded from state only, with no input-to-output path.
- IDLE:
  - If start_i=1 and annul_i=0 and opdata2_i=0, go to BYZERO.
  - If start_i=1 and annul_i=0 and opdata2_i!=0, go to ON. Latch |dividend| and |divisor|; take two's complement only if signed_div_i=1 and the MSB is set. Also latch the sign flags and clear cnt and the partial remainder.
  - Otherwise stay in IDLE. result_o=0, ready_o=0.
- BYZERO:
  - If annul_i=1, go to IDLE.
  - Otherwise go to END with result_o=0 and ready_o=1.
- ON: each cycle with annul_i=0 performs one restoring step:
  - Shift {rem, dividend} left by 1.
  - Compute trial = rem - divisor over DATA_W+1 bits.
  - If trial is non-negative, rem = trial and the shifted-in quotient bit is 1; otherwise rem is unchanged and the quotient bit is 0.
  - cnt increments.
- ON completion: when cnt==DATA_W, apply sign fix-up and go to END with ready_o=1. No iteration occurs in that cycle. Sign fix-up applies only when signed_div_i was latched as 1:
  - Quotient is negated if the operand signs differ.
  - Remainder is negated if the dividend was negative (remainder takes the dividend's sign).
- ON with annul_i=1: go to IDLE immediately, ready_o=0, result_o=0, cnt cleared.
- Latency: start accepted at edge E0. ready_o=1 and result_o valid after edge E0+DATA_W+2 (E0+34 for 32 bits). For divide-by-zero, ready_o=1 after edge E0+2.
- END: hold result_o and ready_o=1 while start_i=1. When start_i=0, go to IDLE, result_o=0, ready_o=0. annul_i is ignored in END.
- start_i changes or operand changes while in ON or BYZERO are ignored; the latched operands are used.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- Operands and signed_div_i are sampled only on the IDLE->ON/BYZERO transition.

Test Plan:
- Unsigned 100 / 7, start held → ready_o rises exactly 34 cycles after the start edge; result_o[31:0]=14, result_o[63:32]=2; busy_o=1 throughout ON. Deasserting start_i → IDLE next cycle, result_o=0.
- Signed -7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 → quotient 0xFFFFFFFD, remainder 1.
- Divide by zero (opdata2_i=0) → busy_o=1 for 1 cycle, ready_o=1 after 2 edges, result_o=0.
- annul_i pulsed at cycle 10 of ON → IDLE next edge, ready_o never asserts. A new start then runs a full 34-cycle division correctly (0xFFFFFFFF/1 unsigned → quotient 0xFFFFFFFF, remainder 0).
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0x80000000 / 0xFFFFFFFF → quotient 0, remainder 0x80000000.
- rst asserted at cycle 20 of ON with start_i still high → next edge: IDLE, all outputs 0. After rst deasserts with start_i high, a fresh division begins.
